// File: rtl/score_row_engine_pkg.sv
// Shared types and helpers for the score row engine: FSM states, alignment
// mode encodings and the signed saturation used for boundary scores.
package score_row_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_CELL,
        ST_DONE
    } state_t;

    localparam logic MODE_GLOBAL = 1'b0;
    localparam logic MODE_LOCAL  = 1'b1;

    // Clamp a 32-bit signed value into the range of an sw-bit signed number.
    // The result is still 32 bits wide; callers keep the low sw bits.
    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v,
                                                        input int sw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (sw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (sw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/score_row_engine_boundary_gen.sv
// Boundary score generator: idx*GAP saturated to SW bits in global mode,
// zero in local mode. Purely combinational.
module boundary_gen
    import score_row_engine_pkg::*;
#(
    parameter int SW  = 9,
    parameter int GAP = -2,
    parameter int IW  = 9
) (
    input  logic [IW-1:0]        idx,
    input  logic                 mode,
    output logic signed [SW-1:0] value
);

    logic signed [31:0] product;
    logic signed [31:0] clamped;
    logic               unused_clamped_hi;

    // Index is a non-negative count, so zero-extend before the signed multiply.
    assign product = $signed({{(32 - IW){1'b0}}, idx}) * GAP;
    assign clamped = sat_to_width(product, SW);
    // After clamping the upper bits are pure sign copies of bit SW-1.
    assign unused_clamped_hi = ^clamped[31:SW];
    assign value = (mode == MODE_LOCAL) ? '0 : clamped[SW-1:0];

endmodule

// File: rtl/score_row_engine.sv
// Row-buffered dynamic-programming score engine. Walks an (N+1)x(N+1) score
// matrix row by row, presenting the diagonal/up/left neighbours of each cell to
// an external consumer and storing the returned score. Only one row is kept.
module score_row_engine
    import score_row_engine_pkg::*;
#(
    parameter int  N   = 128,
    parameter int  SW  = 9,
    parameter int  GAP = -2,
    localparam int IW  = $clog2(N + 1) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 abort,
    output logic                 rd_valid,
    output logic signed [SW-1:0] diag,
    output logic signed [SW-1:0] up,
    output logic signed [SW-1:0] left,
    output logic [IW-1:0]        i,
    output logic [IW-1:0]        j,
    input  logic                 wr_valid,
    input  logic signed [SW-1:0] wr_score,
    output logic                 busy,
    output logic                 done,
    output logic signed [SW-1:0] final_score,
    output logic signed [SW-1:0] max_score,
    output logic [IW-1:0]        max_i,
    output logic [IW-1:0]        max_j
);

    localparam int AW = $clog2(N + 1);

    state_t                state_reg;
    logic                  mode_reg;
    logic [IW-1:0]         k_reg;
    logic [IW-1:0]         i_reg;
    logic [IW-1:0]         j_reg;
    logic signed [SW-1:0]  diag_reg;
    logic signed [SW-1:0]  left_reg;
    logic signed [SW-1:0]  final_reg;
    logic signed [SW-1:0]  max_reg;
    logic [IW-1:0]         max_i_reg;
    logic [IW-1:0]         max_j_reg;
    logic                  rd_valid_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic signed [SW-1:0]  row_buf [0:N];

    logic [AW-1:0]         j_idx;
    logic signed [SW-1:0]  stored;

    // Boundary values: [0] init index k, [1] col(i), [2] col(i+1).
    logic [IW-1:0]         bnd_idx [3];
    logic signed [SW-1:0]  bnd_val [3];

    assign bnd_idx[0] = k_reg;
    assign bnd_idx[1] = i_reg;
    assign bnd_idx[2] = i_reg + IW'(1);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_bnd
            boundary_gen #(
                .SW  (SW),
                .GAP (GAP),
                .IW  (IW)
            ) u_bnd (
                .idx   (bnd_idx[gi]),
                .mode  (mode_reg),
                .value (bnd_val[gi])
            );
        end
    endgenerate

    assign j_idx  = j_reg[AW-1:0];
    // Local alignment floors every stored score at zero.
    assign stored = (mode_reg == MODE_LOCAL && wr_score[SW-1]) ? '0 : wr_score;

    // FSM, row buffer and score tracking share one sequential process.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= MODE_GLOBAL;
            k_reg        <= '0;
            i_reg        <= '0;
            j_reg        <= '0;
            diag_reg     <= '0;
            left_reg     <= '0;
            final_reg    <= '0;
            max_reg      <= '0;
            max_i_reg    <= '0;
            max_j_reg    <= '0;
            rd_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            for (int n = 0; n <= N; n++) begin
                row_buf[n] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                state_reg    <= ST_IDLE;
                rd_valid_reg <= 1'b0;
                busy_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            state_reg <= ST_INIT;
                            busy_reg  <= 1'b1;
                            mode_reg  <= mode;
                            k_reg     <= '0;
                            i_reg     <= '0;
                            j_reg     <= '0;
                            max_reg   <= '0;
                            max_i_reg <= '0;
                            max_j_reg <= '0;
                        end
                    end
                    ST_INIT: begin
                        row_buf[k_reg[AW-1:0]] <= bnd_val[0];
                        if (k_reg == IW'(N)) begin
                            // i_reg is still 0 here, so bnd_val[2] is col(1).
                            state_reg    <= ST_CELL;
                            rd_valid_reg <= 1'b1;
                            i_reg        <= IW'(1);
                            j_reg        <= IW'(1);
                            diag_reg     <= row_buf[0];
                            left_reg     <= bnd_val[2];
                        end else begin
                            k_reg <= k_reg + IW'(1);
                        end
                    end
                    ST_CELL: begin
                        if (wr_valid) begin
                            row_buf[j_idx] <= stored;
                            if (stored > max_reg) begin
                                max_reg   <= stored;
                                max_i_reg <= i_reg;
                                max_j_reg <= j_reg;
                            end
                            if (j_reg != IW'(N)) begin
                                left_reg <= stored;
                                diag_reg <= row_buf[j_idx];
                                j_reg    <= j_reg + IW'(1);
                            end else if (i_reg != IW'(N)) begin
                                i_reg      <= i_reg + IW'(1);
                                j_reg      <= IW'(1);
                                diag_reg   <= bnd_val[1];
                                left_reg   <= bnd_val[2];
                                row_buf[0] <= bnd_val[2];
                            end else begin
                                final_reg    <= stored;
                                state_reg    <= ST_DONE;
                                rd_valid_reg <= 1'b0;
                                busy_reg     <= 1'b0;
                                done_reg     <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_valid    = rd_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign diag        = rd_valid_reg ? diag_reg : '0;
    assign up          = rd_valid_reg ? row_buf[j_idx] : '0;
    assign left        = rd_valid_reg ? left_reg : '0;
    assign i           = i_reg;
    assign j           = j_reg;
    assign final_score = final_reg;
    assign max_score   = max_reg;
    assign max_i       = max_i_reg;
    assign max_j       = max_j_reg;

endmodule

// File: doc/score_row_engine.md
SCORE_ROW_ENGINE -- requirements
Module: score_row_engine

Interface
REQ-001 The block SHALL have parameter N, default 128, giving the sequence length; the matrix is (N+1)x(N+1) with N>=2.
REQ-002 The block SHALL have parameter SW, default 9, giving the signed score width.
REQ-003 The block SHALL have parameter GAP, default -2, giving the signed gap penalty used for boundary initialisation.
REQ-004 The block SHALL have these ports, in this order:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a new matrix.
- mode  in  1  0=global (NW), 1=local (SW); sampled on accepted start.
- abort  in  1  synchronous return to IDLE.
- rd_valid  out  1  diag/up/left/i/j valid for the current cell.
- diag, up, left  out  SW  signed neighbour scores of cell (i,j).
- i, j  out  $clog2(N+1)+1  current cell indices, 1..N.
- wr_valid  in  1  consumer delivers the cell score.
- wr_score  in  SW  signed computed cell score.
- busy  out  1  high in INIT and CELL.
- done  out  1  one-cycle pulse after the last cell is written.
- final_score  out  SW  score of cell (N,N).
- max_score  out  SW  largest stored score.
- max_i, max_j  out  $clog2(N+1)+1  position of max_score.

Function
REQ-005 The block SHALL hold one row buffer buf[0..N] of SW-bit registers plus diag_reg and left_reg; no full-matrix RAM.
REQ-006 The FSM SHALL have states IDLE, INIT, CELL and DONE; start is ignored outside IDLE.
REQ-007 In INIT, buf[k] SHALL be written at k=0..N, one entry per cycle (N+1 cycles): k*GAP in global mode, 0 in local mode.
REQ-008 Boundary products (k*GAP, i*GAP) SHALL saturate to [-2^(SW-1), 2^(SW-1)-1].
REQ-009 After INIT, the block SHALL enter CELL with i=1, j=1, diag=buf[0], up=buf[1] and left=col(1), where col(i)=i*GAP in global mode and 0 in local mode, saturated.
REQ-010 In CELL, rd_valid SHALL be 1 and diag=diag_reg, up=buf[j], left=left_reg, all combinational from registers.
REQ-011 A cell completes in the cycle when rd_valid and wr_valid are both 1; wr_valid in any other cycle SHALL be ignored.
REQ-012 The stored value s SHALL equal wr_score in global mode, and max(wr_score,0) in local mode.
REQ-013 On completion with j<N: buf[j]<=s, left_reg<=s, diag_reg<=old buf[j], j<=j+1, and the next cell is presented in the next cycle.
REQ-014 On completion with j=N and i<N: buf[N]<=s, i<=i+1, j<=1, diag_reg<=col(i), left_reg<=col(i+1), buf[0]<=col(i+1).
REQ-015 On completion with j=N and i=N: buf[N]<=s, final_score<=s, FSM->DONE, and done SHALL be 1 for exactly that cycle, after which the FSM returns to IDLE.
REQ-016 max_score, max_i and max_j SHALL update when s>max_score (strict, so the first occurrence wins); they are cleared to 0 on accepted start.
REQ-017 abort SHALL return the FSM to IDLE next cycle with rd_valid=0 and busy=0; buffer contents are don't-care; abort has priority over wr_valid.
REQ-018 rd_valid, busy and done SHALL all be 0 in IDLE.

Reset
REQ-019 While rst=0, the FSM SHALL be IDLE, all outputs SHALL be 0, and buf, diag_reg and left_reg SHALL be 0.
REQ-020 Reset assertion mid-matrix SHALL abandon the matrix; a new start is required after release.

Structure
REQ-021 A shared package SHALL hold the FSM state enum, the saturate-to-SW function and the mode encodings.
REQ-022 One sub-module, boundary_gen, SHALL compute the saturated k*GAP / 0 boundary value for a given index and mode.

Verification
REQ-023 Global init: N=4, GAP=-2, start → after 5 cycles rd_valid=1 with i=1, j=1, diag=0, up=-2, left=-2.
REQ-024 Advance: at (1,1) write 1 → next cycle (1,2) with diag=-2, up=-4, left=1.
REQ-025 Row wrap: N=4, write all cells of row 1 as 5 → next cell (2,1) with diag=-2, up=5, left=-4; after (4,4) write 7 → done pulse and final_score=7.
REQ-026 Local mode: write -3 at (1,1) → next left=0; write 9 at (2,3) with all other cells 0 → max_score=9, max_i=2, max_j=3.
REQ-027 Saturation: SW=9, N=150, GAP=-2 global → buf[150]=-256 and left=-256 at row 150.
REQ-028 Abort/reset: abort at (2,2) → IDLE next cycle with wr_valid ignored; rst=0 mid-INIT → all outputs 0; subsequent start yields REQ-023 values.
